// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/decoder pair.
package pwm_pkg;

    localparam int W_DEFAULT = 6;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } dec_state_t;

    typedef logic [W_DEFAULT-1:0] duty_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input, plus a delay flop for rising-edge detect.
module pulse_sync_edge (
    input  logic sysclk,
    input  logic rst_n,
    input  logic pulse_async,
    output logic p_s,
    output logic rise
);

    logic s1;
    logic p_d;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            p_s <= 1'b0;
            p_d <= 1'b0;
        end else begin
            s1  <= pulse_async;
            p_s <= s1;
            p_d <= p_s;
        end
    end

    assign rise = p_s & ~p_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers per-frame duty codes from a fixed-length PWM stream, locking frame timing on rising edges.
// state  | meaning
// SEARCH | no frame timing; waiting for a rising edge
// LOCKED | counting high samples, one word per 2^W-cycle frame
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int IDLE_FRAMES = 8
) (
    input  logic         sysclk,
    input  logic         rst_n,
    input  logic         Enable,
    input  logic         Pulse_In,
    output logic [W-1:0] Duty_Out,
    output logic         Duty_Valid,
    output logic         Locked,
    output logic [W-1:0] Frame_Index,
    output logic         Align_Err
);

    localparam logic [W-1:0] POS_LAST = '1;
    localparam logic [7:0]   IDLE_LIM = 8'(IDLE_FRAMES);

    logic p_s;
    logic rise;

    pulse_sync_edge u_sync (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .pulse_async (Pulse_In),
        .p_s         (p_s),
        .rise        (rise)
    );

    dec_state_t   state, state_nxt;
    logic [W-1:0] pos, pos_nxt;
    logic [W:0]   hi_cnt, hi_nxt;
    logic [W:0]   total;
    logic [7:0]   idle_cnt, idle_nxt, idle_inc;
    logic         first_done, first_nxt;
    logic [W-1:0] duty_nxt;
    logic [W-1:0] index_nxt;
    logic         valid_nxt;
    logic         locked_nxt;
    logic         align_nxt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            pos         <= '0;
            hi_cnt      <= '0;
            idle_cnt    <= '0;
            first_done  <= 1'b0;
            Duty_Out    <= '0;
            Duty_Valid  <= 1'b0;
            Locked      <= 1'b0;
            Frame_Index <= '0;
            Align_Err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            hi_cnt      <= hi_nxt;
            idle_cnt    <= idle_nxt;
            first_done  <= first_nxt;
            Duty_Out    <= duty_nxt;
            Duty_Valid  <= valid_nxt;
            Locked      <= locked_nxt;
            Frame_Index <= index_nxt;
            Align_Err   <= align_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        hi_nxt     = hi_cnt;
        idle_nxt   = idle_cnt;
        first_nxt  = first_done;
        duty_nxt   = Duty_Out;
        valid_nxt  = 1'b0;
        locked_nxt = Locked;
        index_nxt  = Frame_Index;
        align_nxt  = 1'b0;
        total      = hi_cnt + {{W{1'b0}}, p_s};
        idle_inc   = idle_cnt + 8'd1;

        if (!Enable) begin
            state_nxt  = SEARCH;
            pos_nxt    = '0;
            hi_nxt     = '0;
            idle_nxt   = '0;
            first_nxt  = 1'b0;
            duty_nxt   = '0;
            locked_nxt = 1'b0;
            index_nxt  = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (rise) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                        pos_nxt    = W'(1);
                        hi_nxt     = (W+1)'(1);
                        idle_nxt   = '0;
                        first_nxt  = 1'b0;
                        index_nxt  = '0;
                    end
                end
                LOCKED: begin
                    // A rise anywhere but frame start abandons the partial frame and relocks on it.
                    if (rise && (pos != '0)) begin
                        align_nxt  = 1'b1;
                        pos_nxt    = W'(1);
                        hi_nxt     = (W+1)'(1);
                        idle_nxt   = '0;
                        first_nxt  = 1'b0;
                        index_nxt  = '0;
                    end else begin
                        pos_nxt = pos + W'(1);
                        hi_nxt  = (pos == '0) ? {{W{1'b0}}, p_s} : total;
                        if (pos == POS_LAST) begin
                            duty_nxt  = total[W] ? '1 : total[W-1:0];
                            valid_nxt = 1'b1;
                            first_nxt = 1'b1;
                            if (first_done) begin
                                index_nxt = Frame_Index + W'(1);
                            end
                            if (total == '0) begin
                                idle_nxt = idle_inc;
                                if (idle_inc >= IDLE_LIM) begin
                                    state_nxt  = SEARCH;
                                    locked_nxt = 1'b0;
                                end
                            end else begin
                                idle_nxt = '0;
                            end
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

endmodule
